mv_loader: RTL
==============

# mv_loader

Upstream feeder for the matrix-vector PE controller. Accepts one frame (a vector, then a matrix) as a valid/ready word stream and writes it into the shared source BRAM using the address layout the PE controller reads. It then pulses `start` and holds off new input until the controller returns `done`. Stream framing errors are detected, and malformed frames are dropped without starting a computation.

## Interface
Parameters:
- VECTOR_SIZE, 4: log2 of dimension; N = 2**VECTOR_SIZE.
- L_RAM_SIZE, 6: log2 of per-PE local RAM depth; requires L_RAM_SIZE >= VECTOR_SIZE.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader accepts word when s_valid && s_ready.
- s_data  in  32  input word (fp32 bit pattern, not interpreted).
- s_last  in  1  marks final word of frame.
- bram_we  out  1  BRAM write strobe.
- bram_wraddr  out  2*L_RAM_SIZE+1  BRAM word address.
- bram_wrdata  out  32  BRAM write data.
- start  out  1  one-cycle pulse to PE controller.
- done  in  1  one-cycle pulse from PE controller.
- busy  out  1  high from start pulse until done received.
- err  out  1  sticky framing-error flag.
- err_clr  in  1  synchronous clear of err.
- frame_cnt  out  16  completed (started and done) frames, wraps at 2**16.

## Operation
- Frame: N vector words, then N*N matrix words in row-major order. Total T = N*(N+1) words; T = 272 for N = 16.
- Address map (word k, zero-based):
  - Vector element j (k = j): address j.
  - Matrix element (i,j) (k = N + i*N + j): address ((i+1) << L_RAM_SIZE) | j.
- Internal counters: word counter wc (0..T-1), row index i, column index j. Addresses come from i/j directly; no multiplier.
- States:
  - S_FILL (reset state): s_ready=1. Each accepted word is written and wc advances.
    - Accepted word with wc==T-1 and s_last=1 -> S_START.
    - wc==T-1 and s_last=0 -> set err, go to S_DRAIN.
    - s_last=1 with wc<T-1 -> set err, reset wc/i/j, stay in S_FILL. That word is still written; the partial frame is discarded because no start is issued.
  - S_DRAIN: s_ready=1. Words are accepted and not written (bram_we=0). Accepted s_last -> S_FILL with counters zeroed.
  - S_START: s_ready=0, start=1 for exactly this cycle -> S_WAIT.
  - S_WAIT: s_ready=0, busy=1. done -> S_FILL, counters zeroed, frame_cnt+1.
- done outside S_WAIT is ignored.
- err_clr clears err. If err_clr and a new error occur in the same cycle, err ends at 1.
- busy is 1 in S_START and S_WAIT.

## Timing
- Reset values: s_ready=1 (S_FILL), bram_we=0, bram_wraddr=0, bram_wrdata=0, start=0, busy=0, err=0, frame_cnt=0. wc/i/j=0.
- Write path is registered. A word accepted in cycle t gives bram_we/bram_wraddr/bram_wrdata in cycle t+1. bram_we is high for exactly one cycle per written word.
- start asserts in cycle t+1 after the final word is accepted in cycle t, coincident with the final BRAM write. The PE controller samples start and reads only from the following cycle, so that write is already committed.
- Back-to-back acceptance: one word per cycle. A full frame takes T cycles minimum, plus 1 start cycle.
- s_ready is a registered function of state only; it does not depend combinationally on s_valid.
- Minimum done-to-s_ready latency: 1 cycle (S_WAIT -> S_FILL on the done edge, ready high the next cycle).
- Asynchronous reset at any point forces S_FILL and the reset values immediately. A partial frame is abandoned and no start is emitted.

## Configuration
- MV_LOADER_BYTESWAP_EN defined: bram_wrdata = byte-reversed s_data ({s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]}), for little-endian host streams.
- Not defined: bram_wrdata = s_data unchanged.
- Addressing, framing and timing are identical in both builds.

## Test plan
- Nominal frame, N=16, data=k for word k, s_valid held high: 272 writes. Word 0 goes to addr 0; word 16 to addr 0x040 (data 16); word 271 to addr 0x40F (row 15 sits at (15+1)<<6 = 0x400, column 15 -> 0x40F). start pulses one cycle, coincident with the last write. Return done 20 cycles later -> frame_cnt=1 and s_ready=1 the next cycle.
- Early s_last on word 100: err=1, no start. Next clean 272-word frame loads normally starting at addr 0 and starts. Assert err_clr -> err=0.
- Missing s_last on word 271, s_last on word 275: err=1, words 272-275 produce no bram_we, then the next frame loads from addr 0.
- Random s_valid gaps (50% duty) over a full frame: write sequence and addresses identical to the nominal case, and start is issued exactly once.
- areset asserted after 150 words: all outputs return to reset values asynchronously. A subsequent full frame loads from addr 0 and starts.
- MV_LOADER_BYTESWAP_EN build, s_data=0x11223344: bram_wrdata=0x44332211. Without the macro: 0x11223344.

Source files
------------

// File: rtl/mv_loader_if.sv
// Word-stream handshake between a frame source and mv_loader.
// master drives the words, slave (the loader) returns s_ready.
interface mv_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/mv_loader.sv
// Loads one vector+matrix frame into the PE source BRAM, then starts the PE.
// Optional MV_LOADER_BYTESWAP_EN: byte-reverse each word before writing.
module mv_loader #(
    parameter int VECTOR_SIZE = 4,
    parameter int L_RAM_SIZE  = 6
) (
    input  logic                    aclk,
    input  logic                    areset,
    mv_loader_if.slave              s,
    output logic                    bram_we,
    output logic [2*L_RAM_SIZE:0]   bram_wraddr,
    output logic [31:0]             bram_wrdata,
    output logic                    start,
    input  logic                    done,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr,
    output logic [15:0]             frame_cnt
);

    localparam int N    = 2**VECTOR_SIZE;
    localparam int T    = N * (N + 1);
    localparam int WC_W = $clog2(T);
    localparam int AW   = 2*L_RAM_SIZE + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(T - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_DRAIN,
        S_START,
        S_WAIT
    } state_t;

    state_t                 r_state;
    logic                   r_s_ready;
    logic                   r_we;
    logic [AW-1:0]          r_addr;
    logic [31:0]            r_data;
    logic                   r_start;
    logic                   r_busy;
    logic                   r_err;
    logic [15:0]            r_frame_cnt;
    logic [WC_W-1:0]        r_wc;
    logic [VECTOR_SIZE-1:0] r_i;
    logic [VECTOR_SIZE-1:0] r_j;
    logic                   r_mat;

    logic                   w_acc;
    logic                   w_last_word;
    logic                   w_j_wrap;
    logic [AW-1:0]          w_addr;
    logic [31:0]            w_data;

    assign w_acc       = s.s_valid && r_s_ready;
    assign w_last_word = (r_wc == WC_LAST);
    assign w_j_wrap    = (r_j == {VECTOR_SIZE{1'b1}});

`ifdef MV_LOADER_BYTESWAP_EN
    assign w_data = {s.s_data[7:0], s.s_data[15:8],
                     s.s_data[23:16], s.s_data[31:24]};
`else
    assign w_data = s.s_data;
`endif

    // Vector words sit at row 0; matrix row i sits at row i+1 of the PE map.
    always_comb begin
        w_addr = '0;
        if (r_mat) begin
            w_addr = ((AW'(r_i) + AW'(1)) << L_RAM_SIZE) | AW'(r_j);
        end else begin
            w_addr = AW'(r_j);
        end
    end

    // Frame FSM: counters, registered BRAM write port and control outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= S_FILL;
            r_s_ready   <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
            r_wc        <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_mat       <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_start <= 1'b0;
            if (err_clr) begin
                r_err <= 1'b0;
            end
            unique case (r_state)
                S_FILL: begin
                    if (w_acc) begin
                        r_we   <= 1'b1;
                        r_addr <= w_addr;
                        r_data <= w_data;
                        if (w_last_word || s.s_last) begin
                            r_wc  <= '0;
                            r_i   <= '0;
                            r_j   <= '0;
                            r_mat <= 1'b0;
                        end
                        if (w_last_word) begin
                            if (s.s_last) begin
                                r_state   <= S_START;
                                r_start   <= 1'b1;
                                r_busy    <= 1'b1;
                                r_s_ready <= 1'b0;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_DRAIN;
                            end
                        end else if (s.s_last) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wc <= r_wc + WC_W'(1);
                            if (w_j_wrap) begin
                                r_j   <= '0;
                                r_mat <= 1'b1;
                                if (r_mat) begin
                                    r_i <= r_i + VECTOR_SIZE'(1);
                                end
                            end else begin
                                r_j <= r_j + VECTOR_SIZE'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_acc && s.s_last) begin
                        r_state <= S_FILL;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        r_state     <= S_FILL;
                        r_s_ready   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign s.s_ready   = r_s_ready;
    assign bram_we     = r_we;
    assign bram_wraddr = r_addr;
    assign bram_wrdata = r_data;
    assign start       = r_start;
    assign busy        = r_busy;
    assign err         = r_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
